// File: rtl/integration_sysinfo.sv
// Avalon-MM system-information slave: build ID, scratch, prescaled uptime counter
// with coherent 64-bit snapshot, control/status and a configurable read pipeline.
module integration_sysinfo #(
  parameter logic [31:0] SYSTEM_ID    = 32'h5334_5055,
  parameter logic [31:0] BUILD_STAMP  = 32'h0000_0000,
  parameter int          COUNT_W      = 64,
  parameter int          PRESCALE     = 1,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        wrap_irq
);

  localparam int          STAGES  = READ_LATENCY - 1;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [31:0] CAPS    = {2'(READ_LATENCY), 7'(COUNT_W), 16'(PRESCALE), 7'b0};

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  bus_req_t             req;
  logic [31:0]          scratch;
  logic [31:0]          snap_hi;
  logic [COUNT_W-1:0]   cnt;
  logic [15:0]          pre_cnt;
  logic                 en;
  logic                 wrap;
  logic                 tick, clr, wrap_clr, wrap_set;
  logic                 wr_scr, wr_ctl, rd_lo;
  logic [31:0]          rdata_sel;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][31:0]  dat_pipe;

  // A read in the same cycle as a write wins; the write is dropped.
  assign req = '{rd: read, wr: write & ~read, addr: address, wdata: writedata, be: byteenable};

  assign wr_scr   = req.wr && (req.addr == 3'd2);
  assign wr_ctl   = req.wr && (req.addr == 3'd5);
  assign rd_lo    = req.rd && (req.addr == 3'd3);
  assign clr      = wr_ctl && req.be[0] && req.wdata[1];
  assign wrap_clr = wr_ctl && req.be[1] && req.wdata[8];
  assign tick     = en && (pre_cnt == PRE_MAX);
  assign wrap_set = tick && !clr && (&cnt);

  always_comb begin
    rdata_sel = '0;
    case (req.addr)
      3'd0: rdata_sel = SYSTEM_ID;
      3'd1: rdata_sel = BUILD_STAMP;
      3'd2: rdata_sel = scratch;
      3'd3: rdata_sel = cnt[31:0];
      3'd4: rdata_sel = snap_hi;
      3'd5: rdata_sel = {23'b0, wrap, 7'b0, en};
      3'd6: rdata_sel = CAPS;
      default: rdata_sel = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch <= '0;
      en      <= 1'b1;
      wrap    <= 1'b0;
      snap_hi <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wr_scr && req.be[b]) scratch[b*8 +: 8] <= req.wdata[b*8 +: 8];
      if (wr_ctl && req.be[0]) en <= req.wdata[0];
      if (wrap_set)      wrap <= 1'b1;
      else if (wrap_clr) wrap <= 1'b0;
      // Snapshot uses the pre-increment count so LO/HI stay a coherent pair.
      if (rd_lo) snap_hi <= 32'(cnt >> 32);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (en) begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) cnt <= cnt + COUNT_W'(1);
    end
  end

  // Data stages load only alongside a valid, so readdata holds between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= req.rd;
      if (req.rd) dat_pipe[0] <= rdata_sel;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign readdata      = dat_pipe[STAGES];
  assign readdatavalid = vld_pipe[STAGES];
  assign wrap_irq      = wrap;

endmodule

// File: tb/tb_integration_sysinfo.sv
// Directed bench for integration_sysinfo with READ_LATENCY=2, PRESCALE=4, COUNT_W=33.
module tb_integration_sysinfo;

  localparam logic [31:0] SYS_ID = 32'h5334_5055;
  localparam logic [31:0] BSTAMP = 32'h2024_0611;
  localparam logic [31:0] CAPS_X = 32'h9080_0200;  // {2, 33, 4, 0}

  logic        clock, reset;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        wrap_irq;

  int n_chk = 0, n_pass = 0, n_rdv = 0, n_exp = 0;
  logic [31:0] d, lo1;

  integration_sysinfo #(
    .SYSTEM_ID(SYS_ID), .BUILD_STAMP(BSTAMP),
    .COUNT_W(33), .PRESCALE(4), .READ_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .wrap_irq(wrap_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (readdatavalid) n_rdv++;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, checks done %0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    address = a; writedata = wd; byteenable = be; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    address = a; read = 1'b1; n_exp++;
    @(negedge clock);
    read = 1'b0;
    chk("rdv_early", {31'b0, readdatavalid}, 32'd0);
    @(negedge clock);
    chk("rdv_lat2", {31'b0, readdatavalid}, 32'd1);
    q = readdata;
  endtask

  // Freeze counter, clear it, load a value, then re-enable: tick lands 4 cycles later.
  task automatic preload(input logic [32:0] v);
    wr(3'd5, 32'h2, 4'h1);
    force dut.cnt = v;
    #1;
    release dut.cnt;
    wr(3'd5, 32'h1, 4'h1);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    @(negedge clock); @(negedge clock);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_rdv", {31'b0, readdatavalid}, 32'd0);
    chk("rst_irq", {31'b0, wrap_irq}, 32'd0);
    reset = 1'b0;

    // uptime: ticks on edges 4,8,..,40 after release
    repeat (40) @(negedge clock);
    rd(3'd3, d); chk("uptime_lo", d, 32'd10);
    rd(3'd4, d); chk("uptime_hi", d, 32'd0);
    wr(3'd5, 32'h0, 4'h1);
    rd(3'd3, lo1);
    repeat (20) @(negedge clock);
    rd(3'd3, d); chk("uptime_hold", d, lo1);
    rd(3'd5, d); chk("ctrl_en0", d, 32'h0);

    rd(3'd0, d); chk("sys_id", d, SYS_ID);
    rd(3'd1, d); chk("build", d, BSTAMP);
    rd(3'd6, d); chk("caps", d, CAPS_X);
    rd(3'd7, d); chk("addr7", d, 32'h0);

    wr(3'd2, 32'hA5A5_A5A5, 4'hF);
    wr(3'd2, 32'h1122_3344, 4'b0101);
    rd(3'd2, d); chk("scratch_be", d, 32'hA522_A544);
    address = 3'd2; read = 1'b1; write = 1'b1; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
    n_exp++;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    @(negedge clock);
    chk("rdwr_rdv", {31'b0, readdatavalid}, 32'd1);
    chk("rdwr_old", readdata, 32'hA522_A544);
    rd(3'd2, d); chk("rdwr_keep", d, 32'hA522_A544);

    // LO read in the increment cycle
    preload(33'h0_FFFF_FFFF);
    repeat (3) @(negedge clock);
    rd(3'd3, d); chk("coh_lo", d, 32'hFFFF_FFFF);
    rd(3'd4, d); chk("coh_hi", d, 32'h0);
    rd(3'd3, d);
    rd(3'd4, d); chk("coh_hi_after", d, 32'h1);

    // wrap at 33-bit all-ones
    preload(33'h1_FFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("wrap_irq", {31'b0, wrap_irq}, 32'd1);
    rd(3'd3, d); chk("wrap_cnt0", d, 32'h0);
    rd(3'd5, d); chk("ctrl_wrap", d, 32'h101);
    wr(3'd5, 32'h0, 4'b1110);
    rd(3'd5, d); chk("ctrl_be_gate", d, 32'h101);
    wr(3'd5, 32'h100, 4'b0010);
    chk("wrap_clr_irq", {31'b0, wrap_irq}, 32'd0);
    rd(3'd5, d); chk("ctrl_clr", d, 32'h1);
    preload(33'h1_FFFF_FFFF);
    repeat (3) @(negedge clock);
    wr(3'd5, 32'h101, 4'b0011);
    chk("wrap_set_wins", {31'b0, wrap_irq}, 32'd1);

    // load snap_hi nonzero so the reset check means something
    preload(33'h1_0000_0005);
    rd(3'd3, d);
    rd(3'd4, d); chk("snap_pre_rst", d, 32'h1);

    // three back-to-back reads, reset between 2nd and 3rd responses
    address = 3'd0; read = 1'b1; n_exp += 2;
    @(negedge clock);
    address = 3'd1;
    @(negedge clock);
    address = 3'd2;
    chk("b2b_rdv1", {31'b0, readdatavalid}, 32'd1);
    chk("b2b_d1", readdata, SYS_ID);
    @(negedge clock);
    read = 1'b0;
    chk("b2b_rdv2", {31'b0, readdatavalid}, 32'd1);
    chk("b2b_d2", readdata, BSTAMP);
    #2 reset = 1'b1;
    #1;
    chk("drop_rdv", {31'b0, readdatavalid}, 32'd0);
    chk("drop_rdata", readdata, 32'd0);
    chk("drop_irq", {31'b0, wrap_irq}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    rd(3'd3, d); chk("post_lo", d, 32'h0);
    rd(3'd4, d); chk("post_hi", d, 32'h0);
    rd(3'd2, d); chk("post_scratch", d, 32'h0);
    rd(3'd5, d); chk("post_ctrl", d, 32'h1);

    repeat (4) @(negedge clock);
    chk("rdv_count", 32'(n_rdv), 32'(n_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
